i2s_tx_stream: RTL and testbench

- Consumer end of the microphone/audio dstream chain: accepts fixed-point samples (e.g. from the low-pass FIR output) on a dstream input.
- Converts them to AUDIO_W-bit two's-complement audio with saturation and buffers them in a small FIFO.
- Serialises them as a mono I2S stream (same sample on left and right), generating BCLK and LRCLK internally for an external DAC/amplifier.

---
 rtl/i2s_tx_stream.sv | 193 +++++++++++++++++++
 tb/tb_i2s_tx_stream.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_stream.sv
// i2s_tx_stream
//   Consumer end of the audio sample stream. Incoming signed fixed-point
//   samples are converted to AUDIO_W-bit two's-complement audio with
//   saturation, buffered in a small FIFO, and serialised as a mono I2S
//   stream (the same sample in the left and right slots). BCLK and LRCLK
//   are generated internally from clk.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   x_data       input sample, signed Q(W-W_FRAC).W_FRAC
//   x_valid      input sample valid
//   x_ready      FIFO can accept a sample this cycle
//   i2s_bclk     bit clock (clk / (2*BCLK_DIV))
//   i2s_lrclk    word select, 0 = left, 1 = right
//   i2s_sd       serial data, MSB first, changes on BCLK falling edges
//   underflow    one-clk pulse when a frame starts with the FIFO empty
//   fifo_level   current FIFO occupancy
module i2s_tx_stream #(
    parameter int W          = 32,
    parameter int W_FRAC     = 16,
    parameter int AUDIO_W    = 16,
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [W-1:0]                x_data,
    input  logic                        x_valid,
    output logic                        x_ready,
    output logic                        i2s_bclk,
    output logic                        i2s_lrclk,
    output logic                        i2s_sd,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int CW = $clog2(2 * AUDIO_W);
    localparam int SW = $clog2(AUDIO_W);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [DW-1:0]      DIV_LAST   = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0]      DIV_ONE    = DW'(1);
    localparam logic [CW-1:0]      C_LAST     = CW'(2 * AUDIO_W - 1);
    localparam logic [CW-1:0]      C_ONE      = CW'(1);
    localparam logic [CW-1:0]      C_SLOT     = CW'(AUDIO_W);
    localparam logic [CW-1:0]      C_LEFT_MSB = CW'(AUDIO_W - 1);
    localparam logic [CW-1:0]      C_LR_HI    = CW'(2 * AUDIO_W - 2);
    localparam logic [PW-1:0]      P_ONE      = PW'(1);
    localparam logic [LW-1:0]      L_ONE      = LW'(1);
    localparam logic [LW-1:0]      L_FULL     = LW'(FIFO_DEPTH);
    localparam logic [AUDIO_W-1:0] SAT_POS    = {1'b0, {(AUDIO_W-1){1'b1}}};
    localparam logic [AUDIO_W-1:0] SAT_NEG    = {1'b1, {(AUDIO_W-1){1'b0}}};

    // Registered state
    logic [DW-1:0]      div_q, div_d;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sd_q, sd_d;
    logic               underflow_q, underflow_d;
    logic [CW-1:0]      c_q, c_d;
    logic [AUDIO_W-1:0] sample_q, sample_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [AUDIO_W-1:0] mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic                 push;
    logic                 pop;
    logic                 bclk_fall;
    logic [SW-1:0]        bit_sel;
    logic [AUDIO_W-1:0]   conv;
    logic [W-W_FRAC-1:0]  int_part;

    // Handshake: a sample transfers on every clk edge where x_valid and
    // x_ready are both high. x_ready depends only on the occupancy register,
    // never on x_valid, so there is no combinational path input -> ready.
    assign x_ready = (level_q != L_FULL);
    assign push    = x_valid & x_ready;

    // Fractional bits below the kept audio window are simply dropped.
    if (W_FRAC >= AUDIO_W) begin : g_low_bits
        logic unused_frac_bits;
        assign unused_frac_bits = ^x_data[W_FRAC-AUDIO_W:0];
    end

    // Keep the Q1.(AUDIO_W-1) window around the binary point. The integer
    // part must be a pure sign extension, otherwise the value is outside
    // [-1,1) and clamps to the rail selected by the sign bit.
    always_comb begin
        int_part = x_data[W-1:W_FRAC];
        conv     = x_data[W_FRAC -: AUDIO_W];
        if ((|int_part) && !(&int_part)) begin
            conv = x_data[W-1] ? SAT_NEG : SAT_POS;
        end
    end

    always_comb begin
        div_d       = div_q + DIV_ONE;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sd_d        = sd_q;
        underflow_d = 1'b0;
        c_d         = c_q;
        sample_d    = sample_q;
        pop         = 1'b0;
        bit_sel     = '0;
        bclk_fall   = 1'b0;

        if (div_q == DIV_LAST) begin
            div_d     = '0;
            bclk_d    = ~bclk_q;
            bclk_fall = bclk_q;
        end

        // Every serial output moves only on the BCLK falling edge so the
        // receiver sees stable data on the rising edge.
        if (bclk_fall) begin
            c_d = (c_q == C_LAST) ? '0 : c_q + C_ONE;
            if (c_d == '0) begin
                // Whole samples only: the FIFO is read at frame start, so a
                // sample never straddles two frames.
                if (level_q != '0) begin
                    pop      = 1'b1;
                    sample_d = mem_q[rd_ptr_q];
                end else begin
                    sample_d    = '0;
                    underflow_d = 1'b1;
                end
            end
            // Left and right slots both send the same sample MSB first.
            if (c_d < C_SLOT) begin
                bit_sel = SW'(C_LEFT_MSB - c_d);
            end else begin
                bit_sel = SW'(C_LAST - c_d);
            end
            sd_d = sample_d[bit_sel];
            // LRCLK leads each slot MSB by one BCLK (I2S one-bit delay).
            lrclk_d = (c_d >= C_LEFT_MSB) && (c_d <= C_LR_HI);
        end

        wr_ptr_d = push ? wr_ptr_q + P_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + P_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + L_ONE;
            2'b01:   level_d = level_q - L_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b1;
            sd_q        <= 1'b0;
            underflow_q <= 1'b0;
            c_q         <= C_LAST;
            sample_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sd_q        <= sd_d;
            underflow_q <= underflow_d;
            c_q         <= c_d;
            sample_q    <= sample_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    // Sample storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= conv;
        end
    end

    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sd     = sd_q;
    assign underflow  = underflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// tb_i2s_tx_stream
//   Bench for i2s_tx_stream with default parameters. A reference model of
//   the FIFO and frame timing pushes one expected sample per frame start
//   into exp_q; a serial decoder pops and compares each received frame.
module tb_i2s_tx_stream;

    localparam int AW         = 16;
    localparam int DIV        = 8;
    localparam int DEPTH      = 4;
    localparam int FRAME      = 4 * AW * DIV;
    localparam int FIRST_FALL = 2 * DIV;
    localparam int BCLK_CYC   = 2 * DIV;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] x_data  = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sd;
    logic        underflow;
    logic [2:0]  fifo_level;

    i2s_tx_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_data     (x_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sd     (i2s_sd),
        .underflow  (underflow),
        .fifo_level (fifo_level)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur (t=%0t)", name, $time);
    endtask

    function automatic logic [15:0] conv_model(input logic [31:0] d);
        logic signed [31:0] v;
        v = $signed(d) >>> 1;
        if (v > 32767)  return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Reference model: FIFO contents and frame-start schedule
    logic [15:0] x_exp = '0;
    logic [15:0] mdl_q[$];
    logic [15:0] exp_q[$];
    int          mdl_cyc  = 0;
    logic        mdl_took = 1'b0;
    logic        mdl_uf   = 1'b0;
    int          cyc_n;
    logic        can_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cyc  <= 0;
            mdl_took <= 1'b0;
            mdl_uf   <= 1'b0;
            mdl_q.delete();
            exp_q.delete();
        end else begin
            cyc_n    = mdl_cyc + 1;
            can_push = x_valid && (mdl_q.size() != DEPTH);
            mdl_uf   <= 1'b0;
            if (cyc_n >= FIRST_FALL && ((cyc_n - FIRST_FALL) % FRAME) == 0) begin
                if (mdl_q.size() != 0) begin
                    exp_q.push_back(mdl_q.pop_front());
                end else begin
                    exp_q.push_back(16'h0000);
                    mdl_uf <= 1'b1;
                end
            end
            if (can_push) mdl_q.push_back(x_exp);
            mdl_took <= can_push;
            mdl_cyc  <= cyc_n;
        end
    end

    // Per-cycle checks and serial decoder, sampled on the falling clk edge
    logic        bclk_prev = 1'b0;
    logic        lr_prev   = 1'b1;
    logic        have_left = 1'b0;
    logic [15:0] sh        = '0;
    logic [15:0] left_word = '0;
    logic [15:0] e_word;
    logic        exp_bclk;
    logic        exp_lr;
    int          c_mdl;
    int          uf_cnt    = 0;
    int          frames    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bclk_prev = 1'b0;
            lr_prev   = 1'b1;
            have_left = 1'b0;
            sh        = '0;
        end else begin
            exp_bclk = ((mdl_cyc / DIV) % 2) == 1;
            if (mdl_cyc < FIRST_FALL) begin
                exp_lr = 1'b1;
            end else begin
                c_mdl  = ((mdl_cyc - FIRST_FALL) / BCLK_CYC) % (2 * AW);
                exp_lr = (c_mdl >= AW - 1) && (c_mdl <= 2 * AW - 2);
            end
            chk("bclk", i2s_bclk, exp_bclk);
            chk("lrclk", i2s_lrclk, exp_lr);
            chk("fifo_level", fifo_level, mdl_q.size());
            chk("x_ready", x_ready, mdl_q.size() != DEPTH);
            chk("underflow", underflow, mdl_uf);
            if (underflow) uf_cnt++;

            if (!bclk_prev && i2s_bclk) begin
                sh = {sh[14:0], i2s_sd};
                if (!lr_prev && i2s_lrclk) begin
                    left_word = sh;
                    have_left = 1'b1;
                end else if (lr_prev && !i2s_lrclk && have_left) begin
                    have_left = 1'b0;
                    if (exp_q.size() == 0) begin
                        fail_now("frame_expected");
                    end else begin
                        e_word = exp_q.pop_front();
                        chk("frame_left", left_word, e_word);
                        chk("frame_right", sh, e_word);
                        frames++;
                    end
                end
                lr_prev = i2s_lrclk;
            end
            bclk_prev = i2s_bclk;
        end
    end

    // Driver tasks (called on a falling clk edge)
    task automatic send(input logic [31:0] d, input logic [15:0] e);
        int n;
        x_data  = d;
        x_exp   = e;
        x_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mdl_took && n < 1200);
        if (!mdl_took) fail_now("send_accept_timeout");
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (mdl_cyc < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (mdl_cyc != target) fail_now("wait_cyc_target");
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (mdl_q.size() != 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (mdl_q.size() != 0) fail_now("wait_empty_timeout");
    endtask

    typedef struct {
        logic [31:0] din;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int          u0;
        int          f;
        int          k;
        int          gap;
        int          kind;
        logic        bp;
        logic [31:0] r32;
        logic [31:0] d;

        vecs[0] = '{32'h0000_8000, 16'h4000};
        vecs[1] = '{32'h0001_8000, 16'h7fff};
        vecs[2] = '{32'hfffe_0000, 16'h8000};
        vecs[3] = '{32'hffff_0000, 16'h8000};
        vecs[4] = '{32'h0000_0002, 16'h0001};
        vecs[5] = '{32'h7fff_ffff, 16'h7fff};
        vecs[6] = '{32'h8000_0000, 16'h8000};
        vecs[7] = '{32'h0000_ffff, 16'h7fff};
        vecs[8] = '{32'hffff_8000, 16'hc000};
        vecs[9] = '{32'h0000_0001, 16'h0000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bclk", i2s_bclk, 1'b0);
        chk("rst_lrclk", i2s_lrclk, 1'b1);
        chk("rst_sd", i2s_sd, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        rst_n = 1'b1;

        // Backpressure from release: 4 accepted, 5th waits for the first pop
        for (int i = 0; i < 4; i++) send(vecs[i].din, vecs[i].exp);
        x_data  = vecs[4].din;
        x_exp   = vecs[4].exp;
        x_valid = 1'b1;
        wait_cyc(10);
        chk("bp_full_level", fifo_level, 3'd4);
        chk("bp_ready_low", x_ready, 1'b0);
        wait_cyc(16);
        chk("bp_ready_after_pop", x_ready, 1'b1);
        chk("bp_level_after_pop", fifo_level, 3'd3);
        wait_cyc(17);
        chk("bp_fifth_accepted", fifo_level, 3'd4);
        for (int i = 5; i < 10; i++) send(vecs[i].din, vecs[i].exp);
        x_valid = 1'b0;

        // Underflow: three empty frames, one pulse each
        wait_empty();
        u0 = uf_cnt;
        repeat (3 * FRAME + 4) @(negedge clk);
        chk("underflow_3_frames", uf_cnt - u0, 3);
        send(32'h0000_6000, 16'h3000);
        x_valid = 1'b0;

        // Push in the same cycle as the frame-start pop at level 2
        wait_empty();
        f = FIRST_FALL + FRAME * ((mdl_cyc - FIRST_FALL) / FRAME + 1);
        send(32'h0000_1234, conv_model(32'h0000_1234));
        send(32'hffff_edcc, conv_model(32'hffff_edcc));
        x_valid = 1'b0;
        wait_cyc(f - 1);
        chk("simul_level_before", fifo_level, 3'd2);
        x_data  = 32'h0000_4321;
        x_exp   = 16'h2190;
        x_valid = 1'b1;
        @(negedge clk);
        chk("simul_level_after", fifo_level, 3'd2);
        x_valid = 1'b0;

        // Random traffic with random gaps
        for (int i = 0; i < 80; i++) begin
            x_valid = 1'b0;
            gap = $urandom_range(0, 700);
            repeat (gap) @(negedge clk);
            kind = $urandom_range(0, 3);
            r32  = $urandom;
            case (kind)
                0, 1:    d = {{16{r32[16]}}, r32[15:0]};
                2:       d = {(r32[31] ? 16'hfffe : 16'h0001), r32[15:0]};
                default: d = r32;
            endcase
            send(d, conv_model(d));
        end
        x_valid = 1'b0;

        // Asynchronous reset mid-frame
        send(32'h0000_2000, 16'h1000);
        send(32'h0000_3000, 16'h1800);
        x_valid = 1'b0;
        repeat (100) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_bclk", i2s_bclk, 1'b0);
        chk("arst_lrclk", i2s_lrclk, 1'b1);
        chk("arst_sd", i2s_sd, 1'b0);
        chk("arst_underflow", underflow, 1'b0);
        chk("arst_level", fifo_level, 3'd0);
        chk("arst_ready", x_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k  = 0;
        bp = 1'b0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (bp && !i2s_bclk) break;
            bp = i2s_bclk;
        end
        chk("first_fall_after_reset", k, 16);
        send(32'hffff_8000, 16'hc000);
        x_valid = 1'b0;
        repeat (2 * FRAME + 100) @(negedge clk);
        chk("frames_pending", exp_q.size() <= 1, 1'b1);
        chk("frames_decoded_min", frames >= 60, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
